// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Read-side consumer for the team's fifo blocks. Four source FIFOs are
// drained in round-robin order, one word at a time. Each captured word is
// routed to one of four destination FIFOs, selected by the word's top two
// bits.
//
// Ports
//   clk              single clock, all state changes on the rising edge
//   reset            synchronous, active-high
//   src_empty[3:0]   Fifo_empty of source FIFOs 3..0
//   src_valid[3:0]   valid_read of source FIFOs 3..0
//   src_data0..3     Fifo_Data_out of each source FIFO
//   dst_almost_full  almost_full of destination FIFOs 3..0
//   dst_full         Fifo_full of destination FIFOs 3..0
//   src_rd[3:0]      one-hot pop strobe to the source Fifo_rd inputs
//   dst_wr[3:0]      one-hot push strobe to the destination Fifo_wr inputs
//   dst_data         shared write data to all destination Fifo_Data_in
//   grant[1:0]       index of the source currently or last served
//   busy             high in any state other than IDLE
//   timeout_error    one-cycle pulse when a pop is abandoned
//   word_count[7:0]  words delivered, wraps 255 -> 0
//   dbg_state[1:0]   current FSM state (IDLE=0, POP=1, WAIT=2, PUSH=3)
//
// Handshake summary (both FIFO sides):
//   Source side is pop/response: one src_rd pulse asks for a word, and the
//   FIFO answers later with a single-cycle src_valid plus data. Only one pop
//   is ever outstanding, so a response can never be confused with another.
//   Destination side is push/stall: dst_wr is only raised when the selected
//   FIFO is not full, and a write occurs in exactly the cycle dst_wr is high.
//
// Parameter limits: BITNUMBER must be at least 3, TIMEOUT at least 1.
// -----------------------------------------------------------------------------
module fifo_drain_arbiter #(
   parameter int BITNUMBER = 6,
   parameter int TIMEOUT   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           src_empty,
   input  logic [3:0]           src_valid,
   input  logic [BITNUMBER-1:0] src_data0,
   input  logic [BITNUMBER-1:0] src_data1,
   input  logic [BITNUMBER-1:0] src_data2,
   input  logic [BITNUMBER-1:0] src_data3,
   input  logic [3:0]           dst_almost_full,
   input  logic [3:0]           dst_full,
   output logic [3:0]           src_rd,
   output logic [3:0]           dst_wr,
   output logic [BITNUMBER-1:0] dst_data,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic                 timeout_error,
   output logic [7:0]           word_count,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_WAIT = 2'd2,
      ST_PUSH = 2'd3
   } state_t;

   // The timeout counter runs 0 .. TIMEOUT-1 across the WAIT cycles.
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t               state_q,         state_d;
   logic [1:0]           grant_q,         grant_d;
   logic [BITNUMBER-1:0] hold_q,          hold_d;
   logic [TW-1:0]        tmo_cnt_q,       tmo_cnt_d;
   logic                 timeout_error_q, timeout_error_d;
   logic [7:0]           word_count_q,    word_count_d;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   logic [3:0]           eligible;
   logic                 pick_found;
   logic [1:0]           pick_idx;
   logic [1:0]           cand;
   logic [BITNUMBER-1:0] sel_data;
   logic [1:0]           dest;

   // Destination index lives in the top two bits of the held word.
   assign dest = hold_q[BITNUMBER-1 -: 2];

   // Any almost_full destination stalls every source: the arbiter does not
   // know a word's destination until after it has been popped.
   always_comb begin
      eligible = ~src_empty;
      if (dst_almost_full != 4'b0000) begin
         eligible = 4'b0000;
      end
   end

   // Round-robin search starting one past the last grant. The fourth
   // candidate wraps back to the last granted source itself, so a lone busy
   // source is served back to back.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = grant_q;
      cand       = grant_q;
      for (int off = 1; off <= 4; off++) begin
         cand = grant_q + 2'(off);
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Data of the granted source; other sources' data and valid are ignored.
   always_comb begin
      sel_data = src_data0;
      case (grant_q)
         2'd0:    sel_data = src_data0;
         2'd1:    sel_data = src_data1;
         2'd2:    sel_data = src_data2;
         default: sel_data = src_data3;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      hold_d          = hold_q;
      tmo_cnt_d       = tmo_cnt_q;
      timeout_error_d = 1'b0;
      word_count_d    = word_count_q;
      src_rd          = 4'b0000;
      dst_wr          = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               state_d = ST_POP;
            end
         end

         ST_POP: begin
            src_rd[grant_q] = 1'b1;
            tmo_cnt_d       = '0;
            state_d         = ST_WAIT;
         end

         ST_WAIT: begin
            // A valid on the last allowed WAIT cycle still wins over the
            // timeout.
            if (src_valid[grant_q]) begin
               hold_d    = sel_data;
               tmo_cnt_d = '0;
               state_d   = ST_PUSH;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_cnt_d       = '0;
               timeout_error_d = 1'b1;
               state_d         = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         ST_PUSH: begin
            // The write strobe follows dst_full combinationally, so a full
            // destination simply holds the FSM here with the data stable.
            if (!dst_full[dest]) begin
               dst_wr[dest] = 1'b1;
               word_count_d = word_count_q + 8'd1;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         grant_q         <= 2'd3;   // source 0 wins the first search
         hold_q          <= '0;
         tmo_cnt_q       <= '0;
         timeout_error_q <= 1'b0;
         word_count_q    <= 8'd0;
      end else begin
         state_q         <= state_d;
         grant_q         <= grant_d;
         hold_q          <= hold_d;
         tmo_cnt_q       <= tmo_cnt_d;
         timeout_error_q <= timeout_error_d;
         word_count_q    <= word_count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The hold register only changes on the WAIT->PUSH edge, so driving
   // dst_data from it keeps the last pushed word visible outside PUSH.
   assign dst_data      = hold_q;
   assign grant         = grant_q;
   assign busy          = (state_q != ST_IDLE);
   assign timeout_error = timeout_error_q;
   assign word_count    = word_count_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_arbiter
//
// Bench for fifo_drain_arbiter. Source FIFOs are modelled as word arrays with
// a two-cycle valid_read response. The expected delivery order is computed
// at word level (round-robin over the source contents) into exp_q, and each
// observed destination write is matched against it.
// -----------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

   localparam int W     = 6;
   localparam int DEPTH = 128;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ---------------------------------------------------------------------------
   // DUT
   // ---------------------------------------------------------------------------
   logic [3:0]   src_empty;
   logic [3:0]   src_valid;
   logic [W-1:0] src_data0, src_data1, src_data2, src_data3;
   logic [3:0]   dst_almost_full;
   logic [3:0]   dst_full;
   logic [3:0]   src_rd;
   logic [3:0]   dst_wr;
   logic [W-1:0] dst_data;
   logic [1:0]   grant;
   logic         busy;
   logic         timeout_error;
   logic [7:0]   word_count;
   logic [1:0]   dbg_state;

   fifo_drain_arbiter #(.BITNUMBER(W), .TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .src_empty       (src_empty),
      .src_valid       (src_valid),
      .src_data0       (src_data0),
      .src_data1       (src_data1),
      .src_data2       (src_data2),
      .src_data3       (src_data3),
      .dst_almost_full (dst_almost_full),
      .dst_full        (dst_full),
      .src_rd          (src_rd),
      .dst_wr          (dst_wr),
      .dst_data        (dst_data),
      .grant           (grant),
      .busy            (busy),
      .timeout_error   (timeout_error),
      .word_count      (word_count),
      .dbg_state       (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Source FIFO contents and environment state
   // ---------------------------------------------------------------------------
   logic [W-1:0] src_mem [4][DEPTH];
   int           src_head [4];
   int           src_tail [4];
   logic [W-1:0] src_dout [4];
   logic [3:0]   mute;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         src_empty[i] = (src_head[i] == src_tail[i]);
      end
   end

   assign src_data0 = src_dout[0];
   assign src_data1 = src_dout[1];
   assign src_data2 = src_dout[2];
   assign src_data3 = src_dout[3];

   // ---------------------------------------------------------------------------
   // Scoreboard and logs
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q [$];
   int           rd_cyc_q [$];
   logic [3:0]   rd_val_q [$];
   int           wr_cyc_q [$];
   logic [3:0]   wr_val_q [$];
   logic [W-1:0] wr_dat_q [$];
   int           to_cyc_q [$];
   logic         to_busy_q [$];
   int           rd_err;
   int           wr_err;
   int           wr_total;
   logic         mon_en;

   int pass_cnt;
   int fail_cnt;
   int total_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total_cnt++;
      assert (obs === exp_v) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Source model + monitor. Runs just after each falling edge, after the main
   // sequence has driven its inputs for the cycle, so everything sampled here
   // is what the DUT sees on the next rising edge.
   // ---------------------------------------------------------------------------
   initial begin : env
      logic [3:0]   p1, p2;
      logic [W-1:0] w1 [4];
      logic [W-1:0] w2 [4];
      logic         prev_reset, prev_busy;
      logic [3:0]   prev_af, prev_empty, exp_rd, exp_dst;
      logic [1:0]   prev_grant;
      logic [W-1:0] e;
      int           idx;
      p1 = 4'b0; p2 = 4'b0;
      prev_reset = 1'b1; prev_busy = 1'b0; prev_af = 4'b0;
      prev_empty = 4'hF; prev_grant = 2'd3;
      src_valid = 4'b0;
      for (int i = 0; i < 4; i++) begin
         w1[i] = '0; w2[i] = '0; src_dout[i] = '0;
      end
      forever begin
         @(negedge clk);
         #1;
         // Source FIFOs: valid_read two cycles after the Fifo_rd cycle.
         for (int i = 0; i < 4; i++) begin
            src_valid[i] = p2[i];
            if (p2[i]) src_dout[i] = w2[i];
            p2[i] = p1[i];
            w2[i] = w1[i];
            p1[i] = 1'b0;
            if (src_rd[i] === 1'b1) begin
               if (src_head[i] == src_tail[i]) begin
                  rd_err++;
               end else begin
                  w1[i] = src_mem[i][src_head[i] % DEPTH];
                  p1[i] = !mute[i];
                  src_head[i]++;
               end
            end
         end
         if (src_rd !== 4'b0000) begin
            rd_cyc_q.push_back(cyc);
            rd_val_q.push_back(src_rd);
            if (!$onehot(src_rd)) rd_err++;
         end

         if (mon_en) begin
            if (prev_reset) wr_total = 0;
            check("word_count", {24'd0, word_count}, wr_total % 256);

            // Pop decision made in the previous IDLE cycle.
            if (!prev_reset && !prev_busy) begin
               exp_rd = 4'b0000;
               if (prev_af == 4'b0000) begin
                  for (int off = 1; off <= 4; off++) begin
                     idx = (int'(prev_grant) + off) % 4;
                     if (exp_rd == 4'b0000 && !prev_empty[idx]) exp_rd = 4'b0001 << idx;
                  end
               end
               check("rr_pick", {28'd0, src_rd}, {28'd0, exp_rd});
            end

            if (dst_wr !== 4'b0000) begin
               wr_cyc_q.push_back(cyc);
               wr_val_q.push_back(dst_wr);
               wr_dat_q.push_back(dst_data);
               if ((dst_wr & dst_full) != 4'b0000 || !$onehot(dst_wr)) wr_err++;
               if (exp_q.size() == 0) begin
                  check("unexpected_write", {28'd0, dst_wr}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  exp_dst = 4'b0001 << e[W-1:W-2];
                  check("sb_data", {26'd0, dst_data}, {26'd0, e});
                  check("sb_dest", {28'd0, dst_wr}, {28'd0, exp_dst});
               end
               wr_total++;
            end

            if (timeout_error === 1'b1) begin
               to_cyc_q.push_back(cyc);
               to_busy_q.push_back(busy);
            end
         end

         prev_reset = reset;
         prev_busy  = busy;
         prev_af    = dst_almost_full;
         prev_grant = grant;
         prev_empty = src_empty;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_src(input int s, input logic [W-1:0] w);
      src_mem[s][src_tail[s] % DEPTH] = w;
      src_tail[s]++;
   endtask

   task automatic clear_logs();
      rd_cyc_q.delete(); rd_val_q.delete();
      wr_cyc_q.delete(); wr_val_q.delete(); wr_dat_q.delete();
      to_cyc_q.delete(); to_busy_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   // Word-level reference: serve the next non-empty source after 'last',
   // one word per turn, until all sources are drained.
   task automatic predict(input int last);
      int h [4];
      int remaining;
      int cur;
      int idx;
      logic done;
      remaining = 0;
      for (int i = 0; i < 4; i++) begin
         h[i] = src_head[i];
         remaining += src_tail[i] - src_head[i];
      end
      cur = last;
      while (remaining > 0) begin
         done = 1'b0;
         for (int off = 1; off <= 4; off++) begin
            idx = (cur + off) % 4;
            if (!done && h[idx] != src_tail[idx]) begin
               exp_q.push_back(src_mem[idx][h[idx] % DEPTH]);
               h[idx]++;
               cur = idx;
               remaining--;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, {31'd0, (n < budget)}, 32'd1);
      tick(2);
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin : main
      int           c;
      int           total;
      int           n;
      logic [W-1:0] w;
      pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
      rd_err = 0; wr_err = 0; wr_total = 0; mon_en = 1'b0;
      mute = 4'b0;
      for (int i = 0; i < 4; i++) begin
         src_head[i] = 0; src_tail[i] = 0;
      end
      reset = 1'b1; dst_almost_full = 4'b0; dst_full = 4'b0;
      tick(3);
      reset = 1'b0;
      mon_en = 1'b1;

      // --- Reset values ---
      check("rst_src_rd",  {28'd0, src_rd}, 32'd0);
      check("rst_dst_wr",  {28'd0, dst_wr}, 32'd0);
      check("rst_dst_data", {26'd0, dst_data}, 32'd0);
      check("rst_grant",   {30'd0, grant}, 32'd3);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_timeout", {31'd0, timeout_error}, 32'd0);
      check("rst_wcount",  {24'd0, word_count}, 32'd0);
      check("rst_state",   {30'd0, dbg_state}, 32'd0);

      // --- Single word 0x2A from source 0 to destination 2 ---
      clear_logs();
      c = cyc;
      push_src(0, 6'h2A);
      predict(3);
      wait_drain("single_drain", 50);
      check("single_rd_count", rd_val_q.size(), 32'd1);
      check("single_rd_val", (rd_val_q.size() > 0) ? {28'd0, rd_val_q[0]} : 32'hFFFF, 32'h1);
      check("single_rd_cyc", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] - c : -1, 32'd1);
      check("single_wr_lat", (wr_cyc_q.size() > 0 && rd_cyc_q.size() > 0) ? wr_cyc_q[0] - rd_cyc_q[0] : -1, 32'd3);
      check("single_wr_val", (wr_val_q.size() > 0) ? {28'd0, wr_val_q[0]} : 32'hFFFF, 32'h4);
      check("single_wcount", {24'd0, word_count}, 32'd1);

      // --- Two words in every source: strict rotation, 5 cycles per word ---
      do_reset();
      clear_logs();
      c = cyc;
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 4; s++) begin
            w = W'($urandom);
            push_src(s, w);
         end
      end
      predict(3);
      wait_drain("rot_drain", 100);
      check("rot_rd_count", rd_val_q.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("rot_order", (rd_val_q.size() > i) ? {28'd0, rd_val_q[i]} : 32'hFFFF, 32'd1 << (i % 4));
      end
      check("rot_last_wr_cyc", (wr_cyc_q.size() == 8) ? wr_cyc_q[7] - c : -1, 32'd39);
      check("rot_wcount", {24'd0, word_count}, 32'd8);
      check("rot_src_empty", {28'd0, src_empty}, 32'hF);

      // --- Reset during WAIT with a late valid afterwards ---
      clear_logs();
      push_src(0, 6'h3C);
      push_src(0, 6'h0B);
      push_src(1, 6'h25);
      tick(2);                    // POP then first WAIT cycle
      check("rw_in_wait", {30'd0, dbg_state}, 32'd2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rw_src_rd",   {28'd0, src_rd}, 32'd0);
      check("rw_dst_wr",   {28'd0, dst_wr}, 32'd0);
      check("rw_dst_data", {26'd0, dst_data}, 32'd0);
      check("rw_grant",    {30'd0, grant}, 32'd3);
      check("rw_busy",     {31'd0, busy}, 32'd0);
      check("rw_timeout",  {31'd0, timeout_error}, 32'd0);
      check("rw_wcount",   {24'd0, word_count}, 32'd0);
      clear_logs();
      predict(3);                 // 0x3C was popped and is gone
      wait_drain("rw_drain", 60);
      check("rw_next_src", (rd_val_q.size() > 0) ? {28'd0, rd_val_q[0]} : 32'hFFFF, 32'h1);
      check("rw_first_word", (wr_dat_q.size() > 0) ? {26'd0, wr_dat_q[0]} : 32'hFFFF, 32'h0B);
      check("rw_wcount_end", {24'd0, word_count}, 32'd2);

      // --- Global stall from dst_almost_full[1] ---
      do_reset();
      clear_logs();
      dst_almost_full = 4'b0010;
      push_src(1, 6'h11);
      push_src(1, 6'h32);
      push_src(3, 6'h07);
      predict(3);
      tick(15);
      check("af_no_rd", rd_val_q.size(), 32'd0);
      check("af_busy",  {31'd0, busy}, 32'd0);
      c = cyc;
      dst_almost_full = 4'b0000;
      wait_drain("af_drain", 60);
      check("af_resume_cyc", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] - c : -1, 32'd1);
      check("af_wcount", {24'd0, word_count}, 32'd3);

      // --- Destination 1 full for 6 cycles while 0x1F sits in PUSH ---
      do_reset();
      clear_logs();
      dst_full = 4'b0010;
      push_src(0, 6'h1F);
      predict(3);
      tick(4);
      check("full_in_push", {30'd0, dbg_state}, 32'd3);
      for (int i = 0; i < 6; i++) begin
         check("full_hold_wr",   {28'd0, dst_wr}, 32'd0);
         check("full_hold_data", {26'd0, dst_data}, 32'h1F);
         tick(1);
      end
      dst_full = 4'b0000;
      wait_drain("full_drain", 20);
      check("full_wr_count", wr_val_q.size(), 32'd1);
      check("full_wr_val", (wr_val_q.size() > 0) ? {28'd0, wr_val_q[0]} : 32'hFFFF, 32'h2);
      check("full_wcount", {24'd0, word_count}, 32'd1);

      // --- Source 0 never answers: pop times out ---
      do_reset();
      clear_logs();
      mute = 4'b0001;
      push_src(0, 6'h05);
      tick(12);
      check("to_count", to_cyc_q.size(), 32'd1);
      check("to_delay", (to_cyc_q.size() > 0 && rd_cyc_q.size() > 0) ? to_cyc_q[0] - rd_cyc_q[0] : -1, 32'd5);
      check("to_busy_low", (to_busy_q.size() > 0) ? {31'd0, to_busy_q[0]} : 32'hFFFF, 32'd0);
      check("to_idle", {31'd0, busy}, 32'd0);
      check("to_wcount", {24'd0, word_count}, 32'd0);
      check("to_grant", {30'd0, grant}, 32'd0);
      check("to_no_write", wr_val_q.size(), 32'd0);
      mute = 4'b0000;

      // --- Randomised drain with random stalls, long enough to wrap word_count ---
      do_reset();
      clear_logs();
      total = 0;
      for (int s = 0; s < 4; s++) begin
         n = $urandom_range(65, 80);
         for (int k = 0; k < n; k++) begin
            w = W'($urandom);
            push_src(s, w);
         end
         total += n;
      end
      predict(3);
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin
         dst_almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         dst_full        = 4'($urandom) & 4'($urandom);
         tick(1);
         n++;
      end
      check("rand_drain", {31'd0, (n < 20000)}, 32'd1);
      dst_almost_full = 4'b0000;
      dst_full        = 4'b0000;
      tick(3);
      check("rand_wcount", {24'd0, word_count}, total % 256);
      check("rand_src_empty", {28'd0, src_empty}, 32'hF);
      check("rand_rd_count", rd_val_q.size(), total);

      // --- FIFO error flags over the whole run ---
      check("no_rd_error", rd_err, 32'd0);
      check("no_wr_error", wr_err, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

- Read-side consumer for the team's `fifo` blocks.
- Drains four source FIFOs in round-robin order, one word at a time, by driving each FIFO's `Fifo_rd`.
- Captures the word when that FIFO's `valid_read` returns it, decodes the destination from the word's top two bits, and writes it into one of four destination FIFOs.
- Applies backpressure from the destination FIFOs' `almost_full`/`Fifo_full`, so it never causes a `Fifo_rd_error` or `Fifo_wr_error` on either side.

## Interface
- `BITNUMBER`, 6: word width; must be ≥ 3. Bits `[BITNUMBER-1:BITNUMBER-2]` are the destination index.
- `TIMEOUT`, 4: maximum number of WAIT cycles allowed for `valid_read` before abandoning a pop.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `src_empty`  in  4  `Fifo_empty` of source FIFOs 3..0.
- `src_valid`  in  4  `valid_read` of source FIFOs 3..0.
- `src_data0` … `src_data3`  in  BITNUMBER each  `Fifo_Data_out` of each source FIFO.
- `dst_almost_full`  in  4  `almost_full` of destination FIFOs 3..0.
- `dst_full`  in  4  `Fifo_full` of destination FIFOs 3..0.
- `src_rd`  out  4  one-hot pop strobe, to each source `Fifo_rd`.
- `dst_wr`  out  4  one-hot push strobe, to each destination `Fifo_wr`.
- `dst_data`  out  BITNUMBER  shared write data to all destination `Fifo_Data_in`.
- `grant`  out  2  index of the source currently or last served.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_error`  out  1  one-cycle pulse when a pop times out.
- `word_count`  out  8  number of words delivered; wraps 255→0.

## Operation
- States: IDLE, POP, WAIT, PUSH.
- Eligibility, evaluated in IDLE:
  - source i is eligible when `src_empty[i]==0`;
  - no source is eligible while any `dst_almost_full` bit is 1 (global stall).
- Round-robin: the search starts at `grant+1` mod 4. The first eligible index is latched into `grant`, and the FSM moves to POP.
- POP: exactly one cycle with `src_rd[grant]=1`; all other `src_rd` bits are 0. Then WAIT.
- WAIT:
  - on the first cycle with `src_valid[grant]==1`: latch `src_data<grant>` into the hold register, go to PUSH, clear the timeout counter;
  - `src_valid` bits of non-granted sources are ignored;
  - if `TIMEOUT` WAIT cycles pass without valid: pulse `timeout_error`, discard the pop, return to IDLE.
- PUSH:
  - `dst_data` = hold register;
  - `dest` = hold[BITNUMBER-1:BITNUMBER-2];
  - `dst_wr[dest] = ~dst_full[dest]`, combinational from state and `dst_full`; other bits are 0;
  - when the write occurs: increment `word_count`, go to IDLE;
  - while `dst_full[dest]==1`: stay in PUSH, hold data stable, `dst_wr=0`.
- Only one pop is outstanding at a time. A second `src_rd` is never issued before the prior word is pushed or timed out.
- `dst_data` holds its last value outside PUSH.

## Timing
- Reset values: state IDLE, `src_rd=0`, `dst_wr=0`, `dst_data=0`, `grant=3` (so source 0 wins first), `busy=0`, `timeout_error=0`, `word_count=0`, timeout counter 0, hold register 0.
- Reset asserted mid-transfer: the held word is dropped and the FSM is in IDLE on the next cycle. An outstanding `src_valid` arriving after reset is ignored.
- Unstalled latency:
  - eligibility seen in IDLE at edge k;
  - `src_rd` high in cycle k+1;
  - with the standard `fifo` (`valid_read` 2 cycles after `Fifo_rd`), `src_valid` is seen in cycle k+3;
  - `dst_wr` is high in cycle k+4.
  - Throughput is one word per 5 cycles.
- `src_empty` lags a pop by one cycle; the at-least-4-cycle spacing between pops hides this lag.
- `dst_almost_full` is sampled only in IDLE. A word already in flight is always pushed, relying on the one free slot that almost_full guarantees.
- `timeout_error` is asserted in the cycle after the TIMEOUT-th WAIT cycle, for one cycle only. `busy` goes to 0 in that same cycle.

## Test plan
- After reset, source 0 holds 0x2A (dest 2), all others empty:
  - `src_rd=0001` one cycle;
  - `dst_wr=0100` with `dst_data=0x2A` 4 cycles later;
  - `word_count=1`; no FIFO error flags.
- All four sources hold two words each:
  - grant order 0,1,2,3,0,1,2,3;
  - 8 words delivered in 40 cycles;
  - `word_count=8`; every source ends empty with no `Fifo_rd_error`.
- `dst_almost_full[1]=1` with sources non-empty:
  - no `src_rd` pulses while it is held;
  - deasserting it resumes popping on the next IDLE cycle.
- Word 0x1F (dest 1) in PUSH while `dst_full[1]=1` for 6 cycles:
  - `dst_wr=0` and `dst_data=0x1F` stable for those 6 cycles;
  - a single `dst_wr=0010` when full drops.
- Source returns no `src_valid` after a pop:
  - `timeout_error` pulses once, 4 WAIT cycles after POP;
  - FSM back in IDLE; `word_count` unchanged.
- Reset asserted in WAIT, and a late `src_valid` arrives afterward:
  - all outputs at reset values;
  - the late valid is ignored; `grant=3`, and source 0 is served next.
